// File: rtl/shutdown_sequencer.sv
// -----------------------------------------------------------------------------
// shutdown_sequencer
//
// Power-rail sequencer for the shutdown controller. Brings NUM_RAILS supply
// enables up in ascending order and down in descending order. Each step waits
// for the matching power-good input, bounded by a timeout, and then holds for a
// fixed settle delay. An orderly shutdown request or a watchdog timeout starts
// power-down. A power-good timeout, or loss of power-good while ON, latches a
// fault that drops every rail at once and only clears on reset.
//
// Optional feature (compile-time macro SHUTDOWN_SEQ_WDT_KICK_EN):
//   defined     - while ON, wdt_kick pulses for one cycle every KICK_CYC cycles
//   not defined - wdt_kick is tied low and no kick counter is built
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   power_on     in   rising edge requests power-up
//   shutdown_req in   rising edge requests orderly power-down
//   wdt_timeout  in   level; high forces power-down
//   pg           in   per-rail power-good, synchronous to clk
//   rail_en      out  per-rail enable, registered
//   state        out  OFF=0, PWR_UP=1, ON=2, PWR_DN=3, FAULT=4
//   busy         out  high in PWR_UP or PWR_DN
//   done         out  one-cycle pulse on entry to ON or to OFF
//   fault        out  high in FAULT
//   wdt_kick     out  watchdog kick pulse (see macro above)
// -----------------------------------------------------------------------------
module shutdown_sequencer #(
    parameter int unsigned CLK_HZ        = 24000000,
    parameter int unsigned NUM_RAILS     = 4,
    parameter int unsigned STEP_US       = 1000,
    parameter int unsigned PG_TIMEOUT_US = 5000,
    parameter int unsigned KICK_MS       = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 power_on,
    input  logic                 shutdown_req,
    input  logic                 wdt_timeout,
    input  logic [NUM_RAILS-1:0] pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic [2:0]           state,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic                 wdt_kick
);

    localparam logic [31:0] STEP_CYC = 32'((CLK_HZ / 1000000) * STEP_US);
    localparam logic [31:0] PG_CYC   = 32'((CLK_HZ / 1000000) * PG_TIMEOUT_US);
    localparam logic [31:0] KICK_CYC = 32'((CLK_HZ / 1000) * KICK_MS);
    localparam int unsigned IDX_W    = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_RAILS < 1 || NUM_RAILS > 8) begin : g_bad_num_rails
        $error("shutdown_sequencer: NUM_RAILS must be in 1..8");
    end
    if (KICK_CYC == 32'd0) begin : g_bad_kick
        $error("shutdown_sequencer: KICK_MS must give a non-zero kick period");
    end

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWR_UP = 3'd1,
        S_ON     = 3'd2,
        S_PWR_DN = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t           st;
    logic [IDX_W-1:0] idx;
    logic [31:0]      cnt;
    logic             settling;

    // -------------------------------------------------------------------------
    // Edge detection. edge_arm stays low for the first cycle after reset so the
    // delay registers can capture the live input level: an input held high
    // through reset therefore never looks like a rising edge.
    // -------------------------------------------------------------------------
    logic edge_arm;
    logic power_on_d;
    logic shutdown_req_d;
    logic power_on_rise;
    logic shutdown_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_arm       <= 1'b0;
            power_on_d     <= 1'b0;
            shutdown_req_d <= 1'b0;
        end else begin
            edge_arm       <= 1'b1;
            power_on_d     <= power_on;
            shutdown_req_d <= shutdown_req;
        end
    end

    assign power_on_rise = edge_arm & power_on & ~power_on_d;
    assign shutdown_rise = edge_arm & shutdown_req & ~shutdown_req_d;

    // -------------------------------------------------------------------------
    // Step bookkeeping shared by PWR_UP and PWR_DN.
    // Each rail has two phases: waiting for pg to reach its target level
    // (settling=0, bounded by PG_CYC) and the settle hold (settling=1). The
    // cycle in which pg is first seen at target counts as the first settle
    // cycle, so a step completes exactly STEP_CYC cycles after pg arrives.
    // -------------------------------------------------------------------------
    logic             trigger;
    logic             pg_ok;
    logic [31:0]      cnt_inc;
    logic             step_done;
    logic             pg_timeout;
    logic [IDX_W-1:0] idx_up;
    logic [IDX_W-1:0] idx_dn;

    always_comb begin
        trigger    = shutdown_rise | wdt_timeout;
        pg_ok      = (st == S_PWR_DN) ? ~pg[idx] : pg[idx];
        cnt_inc    = cnt + 32'd1;
        step_done  = settling ? (cnt_inc >= STEP_CYC)
                              : (pg_ok && (STEP_CYC <= 32'd1));
        pg_timeout = !settling && !pg_ok && (cnt_inc >= PG_CYC);
        idx_up     = idx + 1'b1;
        idx_dn     = idx - 1'b1;
    end

    always_comb begin
        busy = (st == S_PWR_UP) || (st == S_PWR_DN);
    end

    assign state = st;

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= S_OFF;
            rail_en  <= '0;
            idx      <= '0;
            cnt      <= '0;
            settling <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                S_OFF: begin
                    if (power_on_rise && !trigger) begin
                        st       <= S_PWR_UP;
                        idx      <= '0;
                        rail_en  <= NUM_RAILS'(1);
                        cnt      <= '0;
                        settling <= 1'b0;
                    end
                end

                S_PWR_UP: begin
                    if (trigger) begin
                        // Abort: descend from the rail currently being raised.
                        // Its enable drops now so its pg can be waited low.
                        st           <= S_PWR_DN;
                        rail_en[idx] <= 1'b0;
                        cnt          <= '0;
                        settling     <= 1'b0;
                    end else if (pg_timeout) begin
                        st      <= S_FAULT;
                        rail_en <= '0;
                        fault   <= 1'b1;
                    end else if (step_done) begin
                        cnt      <= '0;
                        settling <= 1'b0;
                        if (idx == LAST_IDX) begin
                            st   <= S_ON;
                            done <= 1'b1;
                        end else begin
                            idx             <= idx_up;
                            rail_en[idx_up] <= 1'b1;
                        end
                    end else if (settling || !pg_ok) begin
                        cnt <= cnt_inc;
                    end else begin
                        settling <= 1'b1;
                        cnt      <= 32'd1;
                    end
                end

                S_ON: begin
                    // pg loss wins over a simultaneous shutdown trigger.
                    if (pg != '1) begin
                        st      <= S_FAULT;
                        rail_en <= '0;
                        fault   <= 1'b1;
                    end else if (trigger) begin
                        st                <= S_PWR_DN;
                        idx               <= LAST_IDX;
                        rail_en[LAST_IDX] <= 1'b0;
                        cnt               <= '0;
                        settling          <= 1'b0;
                    end
                end

                S_PWR_DN: begin
                    if (pg_timeout) begin
                        st      <= S_FAULT;
                        rail_en <= '0;
                        fault   <= 1'b1;
                    end else if (step_done) begin
                        cnt      <= '0;
                        settling <= 1'b0;
                        if (idx == '0) begin
                            st   <= S_OFF;
                            done <= 1'b1;
                        end else begin
                            idx             <= idx_dn;
                            rail_en[idx_dn] <= 1'b0;
                        end
                    end else if (settling || !pg_ok) begin
                        cnt <= cnt_inc;
                    end else begin
                        settling <= 1'b1;
                        cnt      <= 32'd1;
                    end
                end

                S_FAULT: begin
                    rail_en <= '0;
                    fault   <= 1'b1;
                end

                default: begin
                    st      <= S_FAULT;
                    rail_en <= '0;
                    fault   <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Watchdog kick
    // -------------------------------------------------------------------------
`ifdef SHUTDOWN_SEQ_WDT_KICK_EN
    logic [31:0] kick_cnt;
    logic        stay_on;

    // Mirrors the ON exit conditions so no kick is issued on the cycle the
    // sequencer leaves ON.
    always_comb begin
        stay_on = (st == S_ON) && (pg == '1) && !trigger;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kick_cnt <= '0;
            wdt_kick <= 1'b0;
        end else begin
            wdt_kick <= 1'b0;
            if (stay_on) begin
                if (kick_cnt + 32'd1 >= KICK_CYC) begin
                    kick_cnt <= '0;
                    wdt_kick <= 1'b1;
                end else begin
                    kick_cnt <= kick_cnt + 32'd1;
                end
            end else begin
                kick_cnt <= '0;
            end
        end
    end
`else
    assign wdt_kick = 1'b0;
`endif

endmodule

// File: tb/tb_shutdown_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shutdown_sequencer
//
// Self-checking bench for shutdown_sequencer. Power-good inputs are driven by
// the bench with a randomized delay after each rail enable changes; expected
// rail_en values and step times come from the rule "a step completes STEP
// cycles after pg reaches its target level" and the rail-mask arithmetic.
// -----------------------------------------------------------------------------
module tb_shutdown_sequencer;

    localparam int unsigned CLK_HZ  = 1000000;
    localparam int unsigned NR      = 3;
    localparam int unsigned STEP_US = 4;
    localparam int unsigned PGT_US  = 10;
    localparam int unsigned KICK_MS = 1;

    localparam int STEP = int'((CLK_HZ / 1000000) * STEP_US);
    localparam int PGT  = int'((CLK_HZ / 1000000) * PGT_US);
    localparam int KICK = int'((CLK_HZ / 1000) * KICK_MS);

    localparam int ST_OFF   = 0;
    localparam int ST_UP    = 1;
    localparam int ST_ON    = 2;
    localparam int ST_DN    = 3;
    localparam int ST_FAULT = 4;

`ifdef SHUTDOWN_SEQ_WDT_KICK_EN
    localparam bit KICK_EN = 1'b1;
`else
    localparam bit KICK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          power_on = 1'b0;
    logic          shutdown_req = 1'b0;
    logic          wdt_timeout = 1'b0;
    logic [NR-1:0] pg = '0;
    logic [NR-1:0] rail_en;
    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic          fault;
    logic          wdt_kick;

    int nchk = 0;
    int nfail = 0;
    int stray_kicks = 0;

    shutdown_sequencer #(
        .CLK_HZ        (CLK_HZ),
        .NUM_RAILS     (NR),
        .STEP_US       (STEP_US),
        .PG_TIMEOUT_US (PGT_US),
        .KICK_MS       (KICK_MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .power_on     (power_on),
        .shutdown_req (shutdown_req),
        .wdt_timeout  (wdt_timeout),
        .pg           (pg),
        .rail_en      (rail_en),
        .state        (state),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .wdt_kick     (wdt_kick)
    );

    always #5 clk = ~clk;

    // A kick outside ON is never legal.
    always @(negedge clk) begin
        if (rst_n && (state != 3'(ST_ON)) && wdt_kick) stray_kicks++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int low_mask(input int k);
        return (1 << k) - 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input int st, input int re,
                               input bit bsy, input bit dn, input bit flt);
        check({tag, ".state"},   32'(state),   32'(st));
        check({tag, ".rail_en"}, 32'(rail_en), 32'(re));
        check({tag, ".busy"},    32'(busy),    32'(bsy));
        check({tag, ".done"},    32'(done),    32'(dn));
        check({tag, ".fault"},   32'(fault),   32'(flt));
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        power_on     = 1'b0;
        shutdown_req = 1'b0;
        wdt_timeout  = 1'b0;
        pg           = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    function automatic int pick_delay(input bit rand_d);
        return rand_d ? int'($urandom_range(0, 5)) : 2;
    endfunction

    // Power-up from OFF; returns at the cycle after ON was reached.
    task automatic power_up(input string tag, input bit rand_d);
        int d;
        power_on = 1'b1;
        tick();
        expect_outs({tag, ".start"}, ST_UP, low_mask(1), 1'b1, 1'b0, 1'b0);
        power_on = 1'b0;
        for (int i = 0; i < int'(NR); i++) begin
            d = pick_delay(rand_d);
            repeat (d) tick();
            pg[i] = 1'b1;
            repeat (STEP - 1) tick();
            check({tag, ".hold"}, 32'(rail_en), 32'(low_mask(i + 1)));
            tick();
            if (i < int'(NR) - 1)
                check({tag, ".step"}, 32'(rail_en), 32'(low_mask(i + 2)));
            else
                expect_outs({tag, ".on"}, ST_ON, low_mask(NR), 1'b0, 1'b1, 1'b0);
        end
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    // Power-down from ON (start=NR-1) or from an aborted PWR_UP (start=idx).
    task automatic power_down(input string tag, input int start, input bit use_wdt,
                              input bit rand_d);
        int d;
        if (use_wdt) wdt_timeout = 1'b1;
        else         shutdown_req = 1'b1;
        tick();
        expect_outs({tag, ".start"}, ST_DN, low_mask(start), 1'b1, 1'b0, 1'b0);
        shutdown_req = 1'b0;
        for (int i = start; i >= 0; i--) begin
            d = pick_delay(rand_d);
            repeat (d) tick();
            pg[i] = 1'b0;
            repeat (STEP - 1) tick();
            check({tag, ".hold"}, 32'(rail_en), 32'(low_mask(i)));
            tick();
            if (i > 0)
                check({tag, ".step"}, 32'(rail_en), 32'(low_mask(i - 1)));
            else
                expect_outs({tag, ".off"}, ST_OFF, 0, 1'b0, 1'b1, 1'b0);
        end
        tick();
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        if (use_wdt) begin
            // Timeout still asserted: a power_on edge must not start power-up.
            power_on = 1'b1;
            tick();
            tick();
            check({tag, ".wdt_blocks_on"}, 32'(state), 32'(ST_OFF));
            power_on    = 1'b0;
            wdt_timeout = 1'b0;
            tick();
        end
    endtask

    initial begin
        // Reset with power_on held high: no edge may be seen on release.
        power_on = 1'b1;
        tick();
        tick();
        expect_outs("reset", ST_OFF, 0, 1'b0, 1'b0, 1'b0);
        check("reset.wdt_kick", 32'(wdt_kick), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("held_high_no_edge", 32'(state), 32'(ST_OFF));
        power_on = 1'b0;
        tick();

        // Directed power-up with pg 2 cycles after each enable (6-cycle steps).
        power_up("up0", 1'b0);

        // Kick cadence while ON; the ON-entry cycle is t=0.
        for (int t = 2; t <= 2 * KICK + 1; t++) begin
            tick();
            check("kick", 32'(wdt_kick), 32'(KICK_EN && (t % KICK == 0)));
        end
        check("kick.still_on", 32'(state), 32'(ST_ON));

        // power_on edges ignored while ON.
        power_on = 1'b1;
        tick();
        tick();
        check("on_ignores_power_on", 32'(state), 32'(ST_ON));
        power_on = 1'b0;
        tick();

        power_down("dn0", NR - 1, 1'b0, 1'b0);

        // Watchdog-triggered power-down.
        power_up("up1", 1'b0);
        power_down("wdt0", NR - 1, 1'b1, 1'b0);

        // Abort while idx=1 in PWR_UP.
        power_on = 1'b1;
        tick();
        power_on = 1'b0;
        repeat (2) tick();
        pg[0] = 1'b1;
        repeat (STEP) tick();
        check("abort.idx1", 32'(rail_en), 32'(low_mask(2)));
        pg[1] = 1'b1;
        tick();
        power_down("abort", 1, 1'b0, 1'b1);

        // Power-good timeout on rail 1.
        do_reset();
        power_on = 1'b1;
        tick();
        power_on = 1'b0;
        repeat (2) tick();
        pg[0] = 1'b1;
        repeat (STEP) tick();
        check("pgto.rail1_up", 32'(rail_en), 32'(low_mask(2)));
        repeat (PGT - 1) tick();
        check("pgto.not_yet", 32'(state), 32'(ST_UP));
        tick();
        expect_outs("pgto.fault", ST_FAULT, 0, 1'b0, 1'b0, 1'b1);
        power_on = 1'b1;
        tick();
        tick();
        power_on = 1'b0;
        tick();
        expect_outs("pgto.sticky", ST_FAULT, 0, 1'b0, 1'b0, 1'b1);

        // pg loss while ON.
        do_reset();
        power_up("up2", 1'b1);
        pg[2] = 1'b0;
        tick();
        expect_outs("pgloss", ST_FAULT, 0, 1'b0, 1'b0, 1'b1);

        // pg loss together with a shutdown edge: fault wins.
        do_reset();
        power_up("up3", 1'b1);
        pg[0]        = 1'b0;
        shutdown_req = 1'b1;
        tick();
        expect_outs("pgloss_vs_sd", ST_FAULT, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of PWR_UP.
        do_reset();
        power_on = 1'b1;
        tick();
        power_on = 1'b0;
        repeat (3) tick();
        check("mid_up.busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        expect_outs("mid_up.reset", ST_OFF, 0, 1'b0, 1'b0, 1'b0);
        check("mid_up.wdt_kick", 32'(wdt_kick), 32'd0);
        pg = '0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Randomized full cycles.
        for (int n = 0; n < 6; n++) begin
            power_up("rnd_up", 1'b1);
            repeat ($urandom_range(0, 20)) tick();
            power_down("rnd_dn", NR - 1, 1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(1, 5)) tick();
        end

        check("stray_kicks", 32'(stray_kicks), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
